// File: rtl/kiwi_kernel_sched.sv
// Shares one start/done/abort kernel between NREQ round-robin requesters, one job at a time.
// Latency: req in IDLE at t -> kern_start at t+1; kern_done at d -> ack at d+1; 4-cycle minimum job.
// Backpressure: req is a level held until ack; later requesters wait in IDLE while a job is busy.
//
// Ports:
//   clk, reset (async, active-low)
//   req/req_arg           per-requester job request level and argument slice
//   ack/ack_status/ack_result  one-hot completion pulse with status (00 ok, 10 abort) and result
//   kern_start/kern_arg/kern_abort/kern_done/kern_result  kernel handshake
//   busy, last_cycles, err_spurious  status outputs
module kiwi_kernel_sched #(
  parameter int NREQ    = 4,
  parameter int ARG_W   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ARG_W-1:0] req_arg,
  output logic [NREQ-1:0]       ack,
  output logic [1:0]            ack_status,
  output logic [ARG_W-1:0]      ack_result,
  output logic                  kern_start,
  output logic [ARG_W-1:0]      kern_arg,
  output logic                  kern_abort,
  input  logic                  kern_done,
  input  logic [ARG_W-1:0]      kern_result,
  output logic                  busy,
  output logic [CNT_W-1:0]      last_cycles,
  output logic                  err_spurious
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDX1_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_COMPLETE,
    S_ABORT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  gnt;       // requester owning the current/most recent job
  logic [IDX_W-1:0]  rr_ptr;    // arbitration search starts here
  logic              mask_vld;  // first IDLE cycle after an ack: ignore req[gnt]
  logic [CNT_W-1:0]  cnt;

  logic [NREQ-1:0]   req_eff;
  logic              any_req;
  logic [IDX_W-1:0]  pick;
  logic [IDX1_W-1:0] cand;
  logic [ARG_W-1:0]  pick_arg;
  logic [NREQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]  rr_nxt;
  logic [CNT_W-1:0]  cnt_inc;

  // Round-robin search from rr_ptr upward, wrapping. The just-acked requester
  // is masked for one cycle so a requester that drops req late is not regranted.
  always_comb begin
    req_eff = req;
    if (mask_vld) req_eff[gnt] = 1'b0;
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + IDX1_W'(k);
      if (cand >= IDX1_W'(NREQ)) cand = cand - IDX1_W'(NREQ);
      if (!any_req && req_eff[cand[IDX_W-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    pick_arg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDX_W'(i)) pick_arg = req_arg[i*ARG_W +: ARG_W];
    end
  end

  assign gnt_oh  = NREQ'(1) << gnt;
  assign rr_nxt  = (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + IDX_W'(1);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // All outputs are registered; pulses default low and are raised on the
  // transition into the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      gnt          <= '0;
      rr_ptr       <= '0;
      mask_vld     <= 1'b0;
      cnt          <= '0;
      ack          <= '0;
      ack_status   <= 2'b00;
      ack_result   <= '0;
      kern_start   <= 1'b0;
      kern_arg     <= '0;
      kern_abort   <= 1'b0;
      busy         <= 1'b0;
      last_cycles  <= '0;
      err_spurious <= 1'b0;
    end else begin
      kern_start <= 1'b0;
      kern_abort <= 1'b0;
      ack        <= '0;
      ack_status <= 2'b00;
      ack_result <= '0;

      if (kern_done && state != S_RUN) err_spurious <= 1'b1;

      case (state)
        S_IDLE: begin
          mask_vld <= 1'b0;
          if (any_req) begin
            gnt        <= pick;
            kern_arg   <= pick_arg;
            kern_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt_inc;
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (kern_done) begin
            last_cycles <= cnt_inc;
            ack         <= gnt_oh;
            ack_status  <= 2'b00;
            ack_result  <= kern_result;
            state       <= S_COMPLETE;
          end else if (cnt == TO_LIM) begin
            last_cycles <= TO_LAST;
            ack         <= gnt_oh;
            ack_status  <= 2'b10;
            kern_abort  <= 1'b1;
            state       <= S_ABORT;
          end
        end
        S_COMPLETE, S_ABORT: begin
          rr_ptr   <= rr_nxt;
          mask_vld <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kiwi_kernel_sched.sv
module tb_kiwi_kernel_sched;

  localparam int NREQ  = 4;
  localparam int ARG_W = 32;
  localparam int CNT_W = 16;
  localparam int TMO   = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*ARG_W-1:0] req_arg;
  logic [NREQ-1:0]       ack;
  logic [1:0]            ack_status;
  logic [ARG_W-1:0]      ack_result;
  logic                  kern_start;
  logic [ARG_W-1:0]      kern_arg;
  logic                  kern_abort;
  logic                  kern_done;
  logic [ARG_W-1:0]      kern_result;
  logic                  busy;
  logic [CNT_W-1:0]      last_cycles;
  logic                  err_spurious;

  int errs   = 0;
  int checks = 0;
  int n_start = 0;
  int n_abort = 0;
  int n_ack   = 0;

  kiwi_kernel_sched #(
    .NREQ(NREQ), .ARG_W(ARG_W), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_arg(req_arg),
    .ack(ack), .ack_status(ack_status), .ack_result(ack_result),
    .kern_start(kern_start), .kern_arg(kern_arg), .kern_abort(kern_abort),
    .kern_done(kern_done), .kern_result(kern_result), .busy(busy),
    .last_cycles(last_cycles), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (kern_start) n_start++;
    if (kern_abort) n_abort++;
    if (ack != '0) n_ack++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},    64'(ack), 64'(0));
    chk({tag, "_status"}, 64'(ack_status), 64'(0));
    chk({tag, "_result"}, 64'(ack_result), 64'(0));
    chk({tag, "_start"},  64'(kern_start), 64'(0));
    chk({tag, "_arg"},    64'(kern_arg), 64'(0));
    chk({tag, "_abort"},  64'(kern_abort), 64'(0));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_cycles"}, 64'(last_cycles), 64'(0));
    chk({tag, "_spur"},   64'(err_spurious), 64'(0));
  endtask

  initial begin
    int g;
    int ns;
    int na;
    reset       = 1'b0;
    req         = '0;
    req_arg     = '0;
    kern_done   = 1'b0;
    kern_result = '0;

    // Reset state
    do_reset();
    chk_all_zero("rst");

    // 1: single job, done in 5th RUN cycle
    req = 4'b0001;
    req_arg[0 +: ARG_W] = 32'h11;
    tick();                                  // LAUNCH
    chk("t1_start", 64'(kern_start), 64'(1));
    chk("t1_arg", 64'(kern_arg), 64'(32'h11));
    chk("t1_busy", 64'(busy), 64'(1));
    req_arg[0 +: ARG_W] = 32'h99;            // must not reach kern_arg
    repeat (5) tick();                       // RUN5
    chk("t1_noack", 64'(ack), 64'(0));
    kern_done = 1'b1;
    kern_result = 32'hAB;
    tick();                                  // COMPLETE
    kern_done = 1'b0;
    chk("t1_ack", 64'(ack), 64'(4'b0001));
    chk("t1_status", 64'(ack_status), 64'(0));
    chk("t1_result", 64'(ack_result), 64'(32'hAB));
    chk("t1_cycles", 64'(last_cycles), 64'(5));
    chk("t1_arg_held", 64'(kern_arg), 64'(32'h11));
    req = '0;
    tick();                                  // IDLE
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_idle_ack", 64'(ack), 64'(0));
    chk("t1_idle_res", 64'(ack_result), 64'(0));
    chk("t1_nstart", 64'(n_start), 64'(1));

    // 2: round robin with all requesters held
    do_reset();
    for (int i = 0; i < NREQ; i++) req_arg[i*ARG_W +: ARG_W] = 32'hA0 + i;
    req = 4'b1111;
    tick();                                  // LAUNCH
    for (int j = 0; j < 5; j++) begin
      g = j % NREQ;
      chk("t2_start", 64'(kern_start), 64'(1));
      chk("t2_arg", 64'(kern_arg), 64'(32'hA0 + g));
      tick();
      tick();
      kern_done = 1'b1;
      kern_result = 32'h100 + j;
      tick();                                // COMPLETE
      kern_done = 1'b0;
      chk("t2_ack", 64'(ack), 64'(1) << g);
      chk("t2_res", 64'(ack_result), 64'(32'h100 + j));
      chk("t2_cycles", 64'(last_cycles), 64'(2));
      if (j == 4) req = '0;
      tick();                                // IDLE
      if (j < 4) tick();                     // next LAUNCH
    end
    chk("t2_idle_busy", 64'(busy), 64'(0));

    // 3: watchdog abort (rr now at 1)
    req = 4'b0100;
    req_arg[2*ARG_W +: ARG_W] = 32'h22;
    tick();                                  // LAUNCH
    chk("t3_start", 64'(kern_start), 64'(1));
    chk("t3_arg", 64'(kern_arg), 64'(32'h22));
    repeat (TMO) tick();                     // last RUN cycle
    chk("t3_noabort_yet", 64'(kern_abort), 64'(0));
    chk("t3_noack_yet", 64'(ack), 64'(0));
    tick();                                  // ABORT
    chk("t3_abort", 64'(kern_abort), 64'(1));
    chk("t3_ack", 64'(ack), 64'(4'b0100));
    chk("t3_status", 64'(ack_status), 64'(2'b10));
    chk("t3_result", 64'(ack_result), 64'(0));
    chk("t3_cycles", 64'(last_cycles), 64'(TMO));
    req = '0;
    tick();                                  // IDLE
    chk("t3_busy", 64'(busy), 64'(0));
    chk("t3_abort_low", 64'(kern_abort), 64'(0));
    chk("t3_status_low", 64'(ack_status), 64'(0));

    // 4: done in the final watchdog cycle wins; then spurious done
    req = 4'b1000;
    req_arg[3*ARG_W +: ARG_W] = 32'h33;
    tick();                                  // LAUNCH
    chk("t4_arg", 64'(kern_arg), 64'(32'h33));
    repeat (TMO) tick();                     // counter == TIMEOUT-1
    kern_done = 1'b1;
    kern_result = 32'h5A;
    tick();                                  // COMPLETE
    kern_done = 1'b0;
    req = '0;
    chk("t4_ack", 64'(ack), 64'(4'b1000));
    chk("t4_status", 64'(ack_status), 64'(0));
    chk("t4_result", 64'(ack_result), 64'(32'h5A));
    chk("t4_noabort", 64'(kern_abort), 64'(0));
    chk("t4_cycles", 64'(last_cycles), 64'(TMO));
    tick();                                  // IDLE
    chk("t4_nabort", 64'(n_abort), 64'(1));
    chk("t4_spur_clear", 64'(err_spurious), 64'(0));
    kern_done = 1'b1;
    tick();
    kern_done = 1'b0;
    chk("t4_spur_set", 64'(err_spurious), 64'(1));
    chk("t4_spur_busy", 64'(busy), 64'(0));
    repeat (3) tick();
    chk("t4_spur_sticky", 64'(err_spurious), 64'(1));
    chk("t4_spur_noack", 64'(ack), 64'(0));

    // 5: requester 2 drops req one cycle late, nobody else requesting
    req = 4'b0100;
    tick();                                  // LAUNCH
    chk("t5_start", 64'(kern_start), 64'(1));
    tick();                                  // RUN1
    kern_done = 1'b1;
    kern_result = 32'h77;
    tick();                                  // COMPLETE
    kern_done = 1'b0;
    chk("t5_ack", 64'(ack), 64'(4'b0100));
    chk("t5_cycles", 64'(last_cycles), 64'(1));
    ns = n_start;
    tick();                                  // IDLE, req[2] still high
    req = '0;
    tick();
    chk("t5_noregrant_start", 64'(kern_start), 64'(0));
    chk("t5_noregrant_busy", 64'(busy), 64'(0));
    tick();
    chk("t5_nstart", 64'(n_start), 64'(ns));

    // 6: reset mid-run (rr at 3), then grant restarts from requester 0
    req = 4'b0010;
    tick();                                  // LAUNCH
    chk("t6_arg", 64'(kern_arg), 64'(32'hA1));
    req = '0;
    tick();                                  // RUN1
    tick();                                  // RUN2
    na = n_ack;
    #2 reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    tick();
    tick();
    chk("t6_noack", 64'(n_ack), 64'(na));
    reset = 1'b1;
    req = 4'b1111;
    tick();                                  // LAUNCH
    chk("t6_start", 64'(kern_start), 64'(1));
    chk("t6_arg0", 64'(kern_arg), 64'(32'hA0));
    req = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
